// File: rtl/sub86_muldiv_if.sv
// rtl/sub86_muldiv_if.sv - START/BUSY/DONE handshake bundle between the sub86 core and the mul/div unit
interface sub86_muldiv_if #(parameter int W = 32);
    logic           START;
    logic [1:0]     OP;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           BUSY;
    logic           DONE;
    logic [W-1:0]   LO;
    logic [W-1:0]   HI;
    logic           DIVZ;

    modport master (output START, OP, A, B, input BUSY, DONE, LO, HI, DIVZ);
    modport slave  (input START, OP, A, B, output BUSY, DONE, LO, HI, DIVZ);
endinterface

// File: rtl/sub86_muldiv.sv
// rtl/sub86_muldiv.sv - iterative W x W multiply / W / W divide, one bit per cycle
// Optional MULDIV_EARLY_EXIT_EN: MUL leaves ITER once the remaining multiplier is zero.
module sub86_muldiv #(
    parameter int W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    sub86_muldiv_if.slave    bus
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
    state_t state, state_n;

    logic [1:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] acc;        // MUL: running product; DIV: {rem, quo}
    logic [2*W-1:0] mcand;      // MUL: shifted multiplicand; DIV: divisor in low half
    logic [W-1:0]   mplr;
    logic [CW-1:0]  cnt;
    logic           neg_res, neg_rem, dz;
    logic [W-1:0]   lo_q, hi_q;
    logic           divz_q;

    logic           is_div, is_sgn, a_neg, b_neg, b_zero;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] acc_mul, acc_div, prod_f;
    logic [W-1:0]   mplr_nx, quo_f, rem_f, rem_nx;
    logic [W:0]     rem_sh, rem_sub;
    logic           ge;
    logic           busy_c, done_c;

    assign is_div = op_q[1];
    assign is_sgn = op_q[0];
    assign a_neg  = is_sgn & a_q[W-1];
    assign b_neg  = is_sgn & b_q[W-1];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;
    assign b_zero = (b_q == '0);

    assign acc_mul = mplr[0] ? acc + mcand : acc;
    assign mplr_nx = mplr >> 1;

    // Restoring step: the shifted-in remainder needs W+1 bits before the compare
    assign rem_sh  = acc[2*W-1:W-1];
    assign ge      = (rem_sh >= {1'b0, mcand[W-1:0]});
    assign rem_sub = rem_sh - {1'b0, mcand[W-1:0]};
    assign rem_nx  = ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
    assign acc_div = {rem_nx, acc[W-2:0], ge};

    assign prod_f = neg_res ? -acc : acc;
    assign quo_f  = neg_res ? -acc[W-1:0] : acc[W-1:0];
    assign rem_f  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_comb begin
        state_n = state;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.START) state_n = S_PREP;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_n = bus.START ? S_PREP : S_IDLE;
            end
            S_PREP: begin
                busy_c = 1'b1;
                if (is_div && b_zero)
                    state_n = S_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
                else if (!is_div && b_mag == '0)
                    state_n = S_FIX;
`endif
                else
                    state_n = S_ITER;
            end
            S_ITER: begin
                busy_c = 1'b1;
                if (cnt == CW'(1))
                    state_n = S_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
                else if (!is_div && mplr_nx == '0)
                    state_n = S_FIX;
`endif
            end
            S_FIX: begin
                busy_c  = 1'b1;
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            divz_q  <= 1'b0;
        end else if (CE) begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        op_q   <= bus.OP;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        divz_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    cnt     <= CW'(W);
                    dz      <= is_div & b_zero;
                    neg_res <= (a_neg ^ b_neg) & ~(is_div & b_zero);
                    neg_rem <= a_neg & ~(is_div & b_zero);
                    if (is_div && b_zero) begin
                        // Divide-by-zero returns the raw dividend in HI, never negated
                        acc <= {a_q, {W{1'b1}}};
                    end else if (is_div) begin
                        acc   <= {{W{1'b0}}, a_mag};
                        mcand <= {{W{1'b0}}, b_mag};
                    end else begin
                        acc   <= '0;
                        mcand <= {{W{1'b0}}, a_mag};
                        mplr  <= b_mag;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= acc_div;
                    end else begin
                        acc   <= acc_mul;
                        mcand <= mcand << 1;
                        mplr  <= mplr_nx;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_q <= quo_f;
                        hi_q <= rem_f;
                    end else begin
                        lo_q <= prod_f[W-1:0];
                        hi_q <= prod_f[2*W-1:W];
                    end
                    divz_q <= dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY = busy_c;
    assign bus.DONE = done_c;
    assign bus.LO   = lo_q;
    assign bus.HI   = hi_q;
    assign bus.DIVZ = divz_q;
endmodule

// File: tb/tb_sub86_muldiv.sv
// tb/tb_sub86_muldiv.sv - directed and randomized checks of sub86_muldiv against an arithmetic model
module tb_sub86_muldiv;
    logic CLK;
    logic RST;
    logic CE;
    int   checks;
    int   errors;

    sub86_muldiv_if #(.W(32)) bus();
    sub86_muldiv #(.W(32)) dut (.CLK(CLK), .RST(RST), .CE(CE), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] mb;
        int k;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = '0;
        k  = 32;
        lo = '0;
        hi = '0;
        if (!op[1]) begin
            if (op[0]) p = sa * sb;
            else       p = {32'b0, a} * {32'b0, b};
            lo = p[31:0];
            hi = p[63:32];
`ifdef MULDIV_EARLY_EXIT_EN
            mb = (op[0] && b[31]) ? -b : b;
            k = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
`else
            mb = b;
`endif
        end else if (b == 32'd0) begin
            dz = 1'b1;
            lo = 32'hFFFF_FFFF;
            hi = a;
            k  = 0;
        end else if (op[0]) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
        lat = 3 + k;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP = op;
        bus.A = a;
        bus.B = b;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.OP = 2'($urandom);
        bus.A = $urandom;
        bus.B = $urandom;
    endtask

    task automatic wait_done(input int lat0, input int stall_at, input int stall_len, output int lat);
        lat = lat0;
        while (!bus.DONE && lat < 300) begin
            if (lat == stall_at) begin
                CE = 1'b0;
                repeat (stall_len) begin
                    @(posedge CLK);
                    #1;
                    lat++;
                end
                CE = 1'b1;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int lat, input int extra);
        logic [31:0] elo, ehi;
        logic edz;
        int elat;
        model(op, a, b, elo, ehi, edz, elat);
        check({tag, " lat"}, 32'(lat), 32'(elat + extra));
        check({tag, " lo"}, bus.LO, elo);
        check({tag, " hi"}, bus.HI, ehi);
        check({tag, " divz"}, 32'(bus.DIVZ), 32'(edz));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(op, a, b);
        wait_done(1, -1, 0, lat);
        finish_op(tag, op, a, b, lat, 0);
        @(posedge CLK);
        #1;
        check({tag, " done pulse"}, 32'(bus.DONE), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return corners[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, seen;
        checks = 0;
        errors = 0;
        RST = 1'b1;
        CE = 1'b1;
        bus.START = 1'b0;
        bus.OP = 2'b00;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst busy", 32'(bus.BUSY), 32'd0);
        check("rst done", 32'(bus.DONE), 32'd0);
        check("rst lo", bus.LO, 32'd0);
        check("rst hi", bus.HI, 32'd0);
        check("rst divz", 32'(bus.DIVZ), 32'd0);
        RST = 1'b0;

        run_op("mulu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulu max hi const", bus.HI, 32'hFFFF_FFFE);
        run_op("muls -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7);
        check("muls lo const", bus.LO, 32'hFFFF_FFEB);
        run_op("mulu 5*3", 2'b00, 32'd5, 32'd3);
        run_op("muls min*min", 2'b01, 32'h8000_0000, 32'h8000_0000);
        check("muls min*min hi", bus.HI, 32'h4000_0000);
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7);
        run_op("divs -100/7", 2'b11, 32'hFFFF_FF9C, 32'd7);
        check("divs rem const", bus.HI, 32'hFFFF_FFFE);
        run_op("divs min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu by0", 2'b10, 32'h1234, 32'd0);
        check("by0 lat const", 32'(lat), 32'(lat));

        start_op(2'b10, 32'd9, 32'd2);
        check("divz cleared", 32'(bus.DIVZ), 32'd0);
        check("lo held", bus.LO, 32'hFFFF_FFFF);
        check("busy after start", 32'(bus.BUSY), 32'd1);
        wait_done(1, -1, 0, lat);
        finish_op("divu 9/2", 2'b10, 32'd9, 32'd2, lat, 0);

        // Back-to-back: START presented in the DONE cycle
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP = 2'b01;
        bus.A = 32'd12345;
        bus.B = 32'hFFFF_FF00;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        check("b2b busy", 32'(bus.BUSY), 32'd1);
        check("b2b done low", 32'(bus.DONE), 32'd0);
        wait_done(1, -1, 0, lat);
        finish_op("b2b muls", 2'b01, 32'd12345, 32'hFFFF_FF00, lat, 0);

        // START pulses while busy must be ignored
        start_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1357);
        lat = 1;
        while (lat < 10) begin
            if (lat == 5) bus.START = 1'b1;
            @(posedge CLK);
            #1;
            bus.START = 1'b0;
            lat++;
        end
        bus.START = 1'b1;
        bus.OP = 2'b11;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        lat++;
        wait_done(lat, -1, 0, lat);
        finish_op("start ignored", 2'b00, 32'hDEAD_BEEF, 32'h0000_1357, lat, 0);

        // CE low for 4 cycles mid-divide
        start_op(2'b11, 32'hF000_1234, 32'd321);
        wait_done(1, 10, 4, lat);
        finish_op("ce stall", 2'b11, 32'hF000_1234, 32'd321, lat, 4);

        // Reset mid-operation
        start_op(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst busy", 32'(bus.BUSY), 32'd0);
        check("midrst done", 32'(bus.DONE), 32'd0);
        check("midrst lo", bus.LO, 32'd0);
        check("midrst hi", bus.HI, 32'd0);
        check("midrst divz", 32'(bus.DIVZ), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) seen++;
        end
        check("midrst no done", 32'(seen), 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d op%0d", n, op), op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
